// File: rtl/seg7_scan.sv
// Multiplexed 4-digit seven-segment scanner with a per-frame input snapshot.
// Optional feature macro: SEG7_LEAD_ZERO_BLANK_EN (suppress leading zero digits).
module seg7_scan #(
   parameter int unsigned DIV   = 50000,
   parameter int unsigned CNT_W = 16,
   parameter int unsigned BLANK = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic [3:0]  dp,
   output logic [3:0]  ds,
   output logic [7:0]  seg,
   output logic        frame
);

   localparam int unsigned IDX_W = 2;
   localparam int unsigned NIB_W = 4;

   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic [15:0]      shadow_v;
   logic [3:0]       shadow_dp;
   logic             tick;
   logic             snap;
   logic [NIB_W-1:0] nib;
   logic             blank_digit;
   logic [3:0]       ds_nxt;
   logic [7:0]       seg_nxt;

   // Active-low segment pattern for one hex nibble, [6:0] = g..a
   function automatic logic [6:0] hex7(input logic [NIB_W-1:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign tick = (cnt == CNT_W'(DIV - 1));
   assign snap = tick && (idx == IDX_W'(3));

   // Prescaler, digit index and frame snapshot
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         idx       <= '0;
         shadow_v  <= 16'h0000;
         shadow_dp <= 4'b0000;
         frame     <= 1'b0;
      end else begin
         cnt   <= tick ? '0 : cnt + CNT_W'(1);
         frame <= snap;
         if (tick) begin
            idx <= idx + IDX_W'(1);
         end
         if (snap) begin
            shadow_v  <= value;
            shadow_dp <= dp;
         end
      end
   end

   always_comb begin
      nib = 4'h0;
      case (idx)
         2'd0: nib = shadow_v[3:0];
         2'd1: nib = shadow_v[7:4];
         2'd2: nib = shadow_v[11:8];
         default: nib = shadow_v[15:12];
      endcase
   end

   // A digit is a leading zero when it and every digit to its left are zero
   always_comb begin
      blank_digit = 1'b0;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
      case (idx)
         2'd3: blank_digit = (shadow_v[15:12] == 4'h0);
         2'd2: blank_digit = (shadow_v[15:8] == 8'h00);
         2'd1: blank_digit = (shadow_v[15:4] == 12'h000);
         default: blank_digit = 1'b0;
      endcase
`endif
   end

   // Dark during the anti-ghosting window at the start of every slot
   always_comb begin
      ds_nxt  = 4'b1111;
      seg_nxt = 8'hFF;
      if (cnt >= CNT_W'(BLANK)) begin
         ds_nxt       = ~(4'b0001 << idx);
         seg_nxt[7]   = ~shadow_dp[idx];
         seg_nxt[6:0] = blank_digit ? 7'h7F : hex7(nib);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ds  <= 4'b1111;
         seg <= 8'hFF;
      end else begin
         ds  <= ds_nxt;
         seg <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with DIV=8, BLANK=2; expected values are hand-computed.
module tb_seg7_scan;

   logic        clk;
   logic        rst;
   logic [15:0] value;
   logic [3:0]  dp;
   logic [3:0]  ds;
   logic [7:0]  seg;
   logic        frame;

   int vectors = 0;
   int errors  = 0;

`ifdef SEG7_LEAD_ZERO_BLANK_EN
   localparam logic [7:0] ZSEG = 8'hFF;
`else
   localparam logic [7:0] ZSEG = 8'hC0;
`endif

   seg7_scan #(.DIV(8), .CNT_W(4), .BLANK(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .value (value),
      .dp    (dp),
      .ds    (ds),
      .seg   (seg),
      .frame (frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] eds, input logic [7:0] eseg);
      vectors++;
      assert (ds === eds) else begin
         errors++;
         $error("FAIL %s ds got %b exp %b", tag, ds, eds);
      end
      vectors++;
      assert (seg === eseg) else begin
         errors++;
         $error("FAIL %s seg got %h exp %h", tag, seg, eseg);
      end
   endtask

   task automatic check_frame(input string tag, input logic efr);
      vectors++;
      assert (frame === efr) else begin
         errors++;
         $error("FAIL %s frame got %b exp %b", tag, frame, efr);
      end
   endtask

   // Advance until the frame pulse is seen, bounded to a bit more than one frame
   task automatic wait_frame(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step(1);
         if (frame === 1'b1) seen = 1'b1;
      end
      vectors++;
      assert (seen === 1'b1) else begin
         errors++;
         $error("FAIL %s frame pulse got %b exp %b", tag, seen, 1'b1);
      end
   endtask

   initial begin
      rst   = 1'b0;
      value = 16'hFFFF;
      dp    = 4'b0000;

      #12;
      check("reset_now", 4'b1111, 8'hFF);
      check_frame("reset_now", 1'b0);
      step(3);
      check("reset_held", 4'b1111, 8'hFF);
      check_frame("reset_held", 1'b0);

      @(negedge clk);
      rst   = 1'b1;
      value = 16'h1234;
      step(1);
      check("post_rst_e1", 4'b1111, 8'hFF);
      step(1);
      check("post_rst_e2", 4'b1111, 8'hFF);
      step(1);
      check("post_rst_first_lit", 4'b1110, 8'hC0);

      wait_frame("first_frame");
      step(1);
      check("scan_blank0", 4'b1111, 8'hFF);
      check_frame("frame_single", 1'b0);
      step(1);
      check("scan_blank1", 4'b1111, 8'hFF);
      step(1);
      check("scan_slot0", 4'b1110, 8'h99);
      step(8);
      check("scan_slot1", 4'b1101, 8'hB0);
      value = 16'hABCD;
      step(8);
      check("tear_slot2", 4'b1011, 8'hA4);
      step(8);
      check("tear_slot3", 4'b0111, 8'hF9);
      step(4);
      check("tear_slot3_end", 4'b0111, 8'hF9);
      check_frame("tear_pre_tick", 1'b0);
      step(1);
      check_frame("tear_tick", 1'b1);
      check("tear_tick_out", 4'b0111, 8'hF9);
      step(1);
      check("tear_blank", 4'b1111, 8'hFF);
      check_frame("tear_pulse_end", 1'b0);
      step(2);
      check("tear_new_slot0", 4'b1110, 8'hA1);

      value = 16'h8888;
      dp    = 4'b0100;
      wait_frame("dp_frame");
      step(3);
      check("dp_slot0", 4'b1110, 8'h80);
      step(8);
      check("dp_slot1", 4'b1101, 8'h80);
      step(8);
      check("dp_slot2", 4'b1011, 8'h00);
      step(8);
      check("dp_slot3", 4'b0111, 8'h80);

      // Land on cnt=5, idx=2 of the following frame, then reset between edges
      step(26);
      check("mid_slot2", 4'b1011, 8'h00);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst", 4'b1111, 8'hFF);
      check_frame("async_rst", 1'b0);

      @(negedge clk);
      rst   = 1'b1;
      value = 16'h0042;
      dp    = 4'b0000;
      step(2);
      check("restart_blank", 4'b1111, 8'hFF);
      step(1);
      check("restart_idx0", 4'b1110, 8'hC0);

      wait_frame("lz_frame");
      step(3);
      check("lz42_slot0", 4'b1110, 8'hA4);
      step(8);
      check("lz42_slot1", 4'b1101, 8'h99);
      step(8);
      check("lz42_slot2", 4'b1011, ZSEG);
      step(8);
      check("lz42_slot3", 4'b0111, ZSEG);

      value = 16'h0000;
      wait_frame("zero_frame");
      step(3);
      check("zero_slot0", 4'b1110, 8'hC0);
      step(8);
      check("zero_slot1", 4'b1101, ZSEG);
      step(8);
      check("zero_slot2", 4'b1011, ZSEG);
      step(8);
      check("zero_slot3", 4'b0111, ZSEG);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Multiplexed 4-digit seven-segment scanner; sits directly downstream of the memory-mapped display register on the MIPS device bus.
- Consumes one 16-bit half of that register and drives one 4-digit common-anode display.
- Samples its input once per scan frame so a bus write never tears mid-frame.
- Two instances per display register: one for the high half, one for the low half.

Parameters:
- DIV, 50000: clocks per digit slot (prescaler terminal count + 1); must be > BLANK.
- CNT_W, 16: prescaler width; 2^CNT_W must be >= DIV.
- BLANK, 16: clocks at the start of each slot with all digits off (anti-ghosting).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- value  input  16  hex value to show; nibble 0 is the rightmost digit
- dp  input  4  decimal-point enables, 1 = lit, bit i belongs to digit i
- ds  output  4  digit selects, active-low, bit i = digit i
- seg  output  8  segments, active-low; [6:0] = g..a, [7] = dp
- frame  output  1  one-clock pulse when a new value/dp snapshot is taken

Behaviour:
- Reset (rst low, asynchronous):
  - cnt=0, idx=0, shadow_v=16'h0000, shadow_dp=4'b0000.
  - ds=4'b1111, seg=8'hFF, frame=0.
- Prescaler:
  - cnt counts 0..DIV-1, then wraps to 0.
  - tick = (cnt==DIV-1).
- Digit index:
  - On tick, idx advances 0→1→2→3→0.
  - idx is 2 bits and wraps naturally.
- Frame snapshot:
  - On tick with idx==3: shadow_v<=value, shadow_dp<=dp, frame<=1 on the next edge; otherwise frame<=0.
  - value/dp changes at any other time are invisible until the next snapshot.
  - The first snapshot after reset occurs at the end of slot 3, i.e. 4*DIV clocks after reset release; the display shows 0000 until then.
- Output stage, registered with one clock of latency from (cnt, idx, shadow):
  - If cnt < BLANK: ds<=4'b1111, seg<=8'hFF.
  - Else: ds<=~(4'b0001<<idx), seg[6:0]<=hex7(shadow_v nibble idx), seg[7]<=~shadow_dp[idx].
- hex7 table (active-low, [6:0]):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Simultaneous events: a tick with idx==3 takes the snapshot and moves idx to 0 on the same edge. The slot-0 outputs therefore use the new snapshot.
- Reset mid-scan: all state returns to reset values immediately; outputs go dark the same instant.
- At most one ds bit is low at any time, and never during the BLANK window.

Optional Feature:
- Macro: SEG7_LEAD_ZERO_BLANK_EN.
- Defined:
  - Digit i (i=3,2,1) is suppressed (seg[6:0]=7'h7F) when shadow_v nibbles i..3 are all zero.
  - Digit 0 is never suppressed.
  - dp still follows shadow_dp; ds timing is unchanged.
  - Example: 16'h0042 shows as "  42".
- Undefined: all four digits are always decoded; 16'h0042 shows as "0042".

Test Plan:
- Reset: hold rst=0 with value=16'hFFFF → ds=4'b1111, seg=8'hFF, frame=0. After release, first lit slot shows digit0 with seg=8'hC0 (shadow still 0).
- Scan order (DIV=8, BLANK=2, value=16'h1234, dp=0):
  - After the first frame pulse, successive slots show ds=1110/seg=99, ds=1101/seg=B0, ds=1011/seg=A4, ds=0111/seg=F9.
  - ds=1111 for the first 2 clocks of each slot.
- Tear-free update: change value 16'h1234→16'hABCD during slot 1 → the current frame finishes as 1234. The frame pulse then fires at the 3→0 tick, and the next slot 0 shows seg=A1 (d).
- Decimal point: dp=4'b0100, value=16'h8888 → seg=8'h00 only in slot 2, seg=8'h80 in the other slots.
- Async reset mid-slot: assert rst at cnt=5, idx=2 → ds=1111 and seg=FF without waiting for clk. After release, scanning restarts at idx 0 with cnt=0.
- With SEG7_LEAD_ZERO_BLANK_EN: value=16'h0042 → slots 3 and 2 show seg=8'hFF, slot 1 shows 99, slot 0 shows A4. value=16'h0000 → only slot 0 is lit, with seg=C0.
